id_hazard_scoreboard: RTL and testbench
=======================================

// Module: id_hazard_scoreboard
// PURPOSE
// - Parametrised hazard/forwarding controller for the ID stage of the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
// - Keeps its own shadow of in-flight destinations in EX/MEM/WB; no longer needs Ern/Mrn fed back from downstream.
// - Per source operand, selects the forwarding source or raises a stall.
// - Tracks a multi-cycle HI/LO divider busy window and counts stall cycles for performance.
// PARAMETERS
// - REG_AW     5   register address width (2**REG_AW GPRs; reg 0 hard-wired zero).
// - DIV_CYCLES 32  cycles HI/LO stay busy after a div/divu issues (1..255).
// - BR_EX_FWD  1   1: ID branch compare may take EX result; 0: stall branch on EX match.
// - PERF_W     32  width of stall performance counter.
// PORTS
// - clk           in   1       rising-edge clock.
// - rst           in   1       synchronous active-high reset.
// - id_valid      in   1       valid instruction in ID.
// - id_flush      in   1       kill ID instruction (taken branch/jump redirect).
// - id_rs, id_rt  in   REG_AW  source register numbers.
// - id_use_rs     in   1       instruction reads rs.
// - id_use_rt     in   1       instruction reads rt.
// - id_is_branch  in   1       rs/rt are consumed by the ID branch compare.
// - id_wr_rf      in   1       instruction writes GPR.
// - id_rd         in   REG_AW  destination register.
// - id_is_load    in   1       result is available only from MEM (dmem).
// - id_is_div     in   1       starts the multi-cycle divider.
// - id_use_hilo   in   1       reads/writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
// - stall         out  1       hold PC and IF/ID; insert bubble into EX.
// - id_issue      out  1       id_valid & ~stall & ~id_flush.
// - fwd_rs        out  2       00 regfile, 01 EX, 10 MEM, 11 WB.
// - fwd_rt        out  2       same encoding as fwd_rs.
// - hilo_busy     out  1       divider window open.
// - perf_stall    out  PERF_W  saturating count of stall cycles.
// BEHAVIOUR
// - Shadow stages: ex/mem/wb {v, rd, load}.
//   - Each clk: wb<=mem, mem<=ex, ex<={id_issue & id_wr_rf & (id_rd!=0), id_rd, id_is_load}.
//   - On stall or flush, ex.v<=0 (bubble).
// - Match on operand X (rs/rt) at stage S: use_X & S.v & (S.rd==X) & (X!=0).
// - Priority is youngest first: EX > MEM > WB. fwd_X is the code of the first matching stage, else 00.
// - Load-use: EX match with ex.load=1 -> stall (1 cycle). Next cycle the op sits in MEM and fwd=10.
// - Branch: id_is_branch & EX match & BR_EX_FWD=0 -> stall. When BR_EX_FWD=1, EX match is legal unless it is a load.
// - Divider: div_cnt (8b). If id_issue & id_is_div, then div_cnt<=DIV_CYCLES; else if div_cnt!=0, div_cnt<=div_cnt-1.
//   - hilo_busy = (div_cnt!=0).
//   - id_use_hilo & hilo_busy -> stall.
//   - A div issued at cycle t: cycles t+1..t+DIV_CYCLES busy; HI/LO consumer issues at t+DIV_CYCLES+1.
// - stall = id_valid & ~id_flush & (load_use | br_stall | hilo_stall). Flush overrides stall (stall=0).
// - Outputs are combinational from inputs and shadow registers. No output depends on id_* when id_valid=0, except fwd_*.
//   fwd_* are still computed when id_valid=0 but are don't-care.
// - perf_stall increments when stall=1 and saturates at all-ones.
// - Reset (sync, any cycle, including mid-divide):
//   - all shadow v=0, div_cnt=0, perf_stall=0.
//   - Therefore stall=0, fwd_*=00, hilo_busy=0, id_issue=id_valid&~id_flush.
// - Writes to reg 0 are never tracked. rs==rt both matching produce identical fwd codes.
// - DIV_CYCLES=1: exactly one busy cycle.
// TESTING
// - Back-to-back ALU ops:
//   - addu $3 issues, then ID reads rs=$3 -> fwd_rs=01, stall=0.
//   - One cycle later -> 10; two cycles later -> 11; three cycles later -> 00.
// - Load-use: lw $5 issues, then ID uses rt=$5 -> stall=1 one cycle, ex bubble; next cycle fwd_rt=10, issue=1, perf_stall=1.
// - $0 hazard: addu $0 issues, then ID reads rs=$0 -> fwd_rs=00, stall=0.
// - Youngest wins: $7 written in MEM and in EX -> fwd_rs=01.
// - Branch with BR_EX_FWD=0: beq reads $4 while $4 in EX -> one-cycle stall, then fwd=10.
//   - With BR_EX_FWD=1: no stall, fwd=01.
// - Divider with DIV_CYCLES=4:
//   - div at t, mflo at t+1 -> stall cycles t+1..t+4, issue at t+5, hilo_busy low from t+5.
//   - Assert rst at t+2 -> hilo_busy=0, stall=0 the next cycle.
// - Flush with pending load-use -> stall=0, id_issue=0, ex bubble. perf_stall saturates at 2**PERF_W-1 with PERF_W=4.

Source files
------------

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard and forwarding controller for a 5-stage MIPS pipeline.
//
// Keeps a private shadow of the destinations in flight in EX/MEM/WB and uses it to
// choose a forwarding source for each source operand, or to stall the ID stage.
// Also tracks the busy window of the multi-cycle HI/LO divider and counts stall cycles.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_valid, id_flush            ID slot holds an instruction / kill it
//   id_rs, id_rt, id_use_rs/rt    source operands and their use flags
//   id_is_branch                  operands feed the ID branch compare
//   id_wr_rf, id_rd, id_is_load   destination write info
//   id_is_div, id_use_hilo        divider start / HI/LO access
//   stall, id_issue               hold IF/ID and bubble EX / instruction moves on
//   fwd_rs, fwd_rt                00 regfile, 01 EX, 10 MEM, 11 WB
//   hilo_busy                     divider window open
//   perf_stall                    saturating stall-cycle counter
module id_hazard_scoreboard #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DIV_CYCLES = 32,
  parameter bit          BR_EX_FWD  = 1'b1,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_flush,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_branch,
  input  logic              id_wr_rf,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              id_is_div,
  input  logic              id_use_hilo,
  output logic              stall,
  output logic              id_issue,
  output logic [1:0]        fwd_rs,
  output logic [1:0]        fwd_rt,
  output logic              hilo_busy,
  output logic [PERF_W-1:0] perf_stall
);

  // Shadow pipeline of in-flight destinations
  logic              ex_v_q, mem_v_q, wb_v_q;
  logic [REG_AW-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic              ex_ld_q, mem_ld_q, wb_ld_q;
  logic              ex_v_d;

  logic [7:0]        div_cnt_q, div_cnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic rs_ex, rs_mem, rs_wb;
  logic rt_ex, rt_mem, rt_wb;
  logic load_use, br_stall, hilo_stall;

  // Operand match per stage; register 0 never matches
  always_comb begin
    rs_ex  = id_use_rs & ex_v_q  & (ex_rd_q  == id_rs) & (id_rs != '0);
    rs_mem = id_use_rs & mem_v_q & (mem_rd_q == id_rs) & (id_rs != '0);
    rs_wb  = id_use_rs & wb_v_q  & (wb_rd_q  == id_rs) & (id_rs != '0);
    rt_ex  = id_use_rt & ex_v_q  & (ex_rd_q  == id_rt) & (id_rt != '0);
    rt_mem = id_use_rt & mem_v_q & (mem_rd_q == id_rt) & (id_rt != '0);
    rt_wb  = id_use_rt & wb_v_q  & (wb_rd_q  == id_rt) & (id_rt != '0);
  end

  // Youngest producer wins
  always_comb begin
    if (rs_ex)       fwd_rs = 2'b01;
    else if (rs_mem) fwd_rs = 2'b10;
    else if (rs_wb)  fwd_rs = 2'b11;
    else             fwd_rs = 2'b00;

    if (rt_ex)       fwd_rt = 2'b01;
    else if (rt_mem) fwd_rt = 2'b10;
    else if (rt_wb)  fwd_rt = 2'b11;
    else             fwd_rt = 2'b00;
  end

  always_comb begin
    hilo_busy  = (div_cnt_q != 8'd0);
    load_use   = (rs_ex | rt_ex) & ex_ld_q;
    // With EX forwarding into the branch comparator, only a load in EX must wait
    br_stall   = id_is_branch & (rs_ex | rt_ex) & ~BR_EX_FWD;
    hilo_stall = id_use_hilo & hilo_busy;
    stall      = id_valid & ~id_flush & (load_use | br_stall | hilo_stall);
    id_issue   = id_valid & ~stall & ~id_flush;
    ex_v_d     = id_issue & id_wr_rf & (id_rd != '0);
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (id_issue && id_is_div) begin
      div_cnt_d = 8'(DIV_CYCLES);
    end else if (div_cnt_q != 8'd0) begin
      div_cnt_d = div_cnt_q - 8'd1;
    end
  end

  always_comb begin
    perf_d = perf_q;
    if (stall && (perf_q != {PERF_W{1'b1}})) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q    <= 1'b0;
      mem_v_q   <= 1'b0;
      wb_v_q    <= 1'b0;
      ex_rd_q   <= '0;
      mem_rd_q  <= '0;
      wb_rd_q   <= '0;
      ex_ld_q   <= 1'b0;
      mem_ld_q  <= 1'b0;
      wb_ld_q   <= 1'b0;
      div_cnt_q <= 8'd0;
      perf_q    <= '0;
    end else begin
      wb_v_q    <= mem_v_q;
      wb_rd_q   <= mem_rd_q;
      wb_ld_q   <= mem_ld_q;
      mem_v_q   <= ex_v_q;
      mem_rd_q  <= ex_rd_q;
      mem_ld_q  <= ex_ld_q;
      ex_v_q    <= ex_v_d;
      ex_rd_q   <= id_rd;
      ex_ld_q   <= id_is_load;
      div_cnt_q <= div_cnt_d;
      perf_q    <= perf_d;
    end
  end

  assign perf_stall = perf_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
module tb_id_hazard_scoreboard;

  localparam int NC = 2200;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_use_rs, id_use_rt, id_is_branch, id_wr_rf, id_is_load, id_is_div, id_use_hilo;

  // dut0: BR_EX_FWD=0, DIV_CYCLES=4, PERF_W=4; dut1: BR_EX_FWD=1, DIV_CYCLES=1, PERF_W=8
  logic       stall0, issue0, hilo0, stall1, issue1, hilo1;
  logic [1:0] fwd_rs0, fwd_rt0, fwd_rs1, fwd_rt1;
  logic [3:0] perf0;
  logic [7:0] perf1;

  always #5 clk = ~clk;

  id_hazard_scoreboard #(.REG_AW(5), .DIV_CYCLES(4), .BR_EX_FWD(1'b0), .PERF_W(4)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush), .id_rs(id_rs),
    .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
    .id_wr_rf(id_wr_rf), .id_rd(id_rd), .id_is_load(id_is_load), .id_is_div(id_is_div),
    .id_use_hilo(id_use_hilo), .stall(stall0), .id_issue(issue0), .fwd_rs(fwd_rs0),
    .fwd_rt(fwd_rt0), .hilo_busy(hilo0), .perf_stall(perf0)
  );

  id_hazard_scoreboard #(.REG_AW(5), .DIV_CYCLES(1), .BR_EX_FWD(1'b1), .PERF_W(8)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush), .id_rs(id_rs),
    .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
    .id_wr_rf(id_wr_rf), .id_rd(id_rd), .id_is_load(id_is_load), .id_is_div(id_is_div),
    .id_use_hilo(id_use_hilo), .stall(stall1), .id_issue(issue1), .fwd_rs(fwd_rs1),
    .fwd_rt(fwd_rt1), .hilo_busy(hilo1), .perf_stall(perf1)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: a log of what each DUT configuration issued in each cycle
  int  cyc = 0;
  bit  h_wr [2][NC];
  int  h_rd [2][NC];
  bit  h_ld [2][NC];
  int  last_rst [2] = '{-1, -1};
  int  last_div [2] = '{-1000, -1000};
  int  pcnt [2] = '{0, 0};
  bit  brf  [2] = '{1'b0, 1'b1};
  int  divc [2] = '{4, 1};
  int  pmax [2] = '{15, 255};
  bit  e_st [2];
  bit  e_is [2];
  bit  chk = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
  endtask

  // Age in cycles (1..3) of the youngest live writer of reg x, or 0 if none
  function automatic int age_of(input int d, input int x, input bit use_x);
    if (!use_x || x == 0) return 0;
    for (int a = 1; a <= 3; a++) begin
      int c = cyc - a;
      if (c > last_rst[d] && c >= 0 && h_wr[d][c] && h_rd[d][c] == x) return a;
    end
    return 0;
  endfunction

  task automatic model_check();
    for (int d = 0; d < 2; d++) begin
      int  ars, art;
      bit  lu, bs, busy, hs;
      int  o_st, o_is, o_rs, o_rt, o_hb, o_pf;
      ars  = age_of(d, int'(id_rs), id_use_rs);
      art  = age_of(d, int'(id_rt), id_use_rt);
      lu   = (ars == 1 || art == 1) && h_ld[d][cyc-1];
      bs   = id_is_branch && (ars == 1 || art == 1) && !brf[d];
      busy = (last_div[d] > last_rst[d]) && (cyc - last_div[d] <= divc[d]);
      hs   = id_use_hilo && busy;
      e_st[d] = id_valid && !id_flush && (lu || bs || hs);
      e_is[d] = id_valid && !id_flush && !e_st[d];
      if (d == 0) begin
        o_st = int'(stall0); o_is = int'(issue0); o_rs = int'(fwd_rs0);
        o_rt = int'(fwd_rt0); o_hb = int'(hilo0); o_pf = int'(perf0);
      end else begin
        o_st = int'(stall1); o_is = int'(issue1); o_rs = int'(fwd_rs1);
        o_rt = int'(fwd_rt1); o_hb = int'(hilo1); o_pf = int'(perf1);
      end
      if (chk) begin
        check($sformatf("stall%0d", d), o_st, int'(e_st[d]));
        check($sformatf("issue%0d", d), o_is, int'(e_is[d]));
        check($sformatf("hilo_busy%0d", d), o_hb, int'(busy));
        check($sformatf("perf%0d", d), o_pf, pcnt[d]);
        if (id_valid) begin
          check($sformatf("fwd_rs%0d", d), o_rs, ars);
          check($sformatf("fwd_rt%0d", d), o_rt, art);
        end
      end
    end
  endtask

  task automatic drive(input bit r, v, fl, input int rs, rt, input bit urs, urt, br, wr,
                       input int rd, input bit ld, dv, hl);
    rst = r; id_valid = v; id_flush = fl; id_rs = 5'(rs); id_rt = 5'(rt);
    id_use_rs = urs; id_use_rt = urt; id_is_branch = br; id_wr_rf = wr; id_rd = 5'(rd);
    id_is_load = ld; id_is_div = dv; id_use_hilo = hl;
    #1;
    model_check();
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      h_wr[d][cyc] = e_is[d] && id_wr_rf && id_rd != 5'd0;
      h_rd[d][cyc] = int'(id_rd);
      h_ld[d][cyc] = id_is_load;
      if (e_is[d] && id_is_div) last_div[d] = cyc;
      if (rst) begin
        last_rst[d] = cyc;
        pcnt[d] = 0;
      end else if (e_st[d] && pcnt[d] < pmax[d]) begin
        pcnt[d]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk = 1'b1;
  endtask

  initial begin
    //    rst v fl rs rt urs urt br wr rd ld dv hl
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_perf", int'(perf0), 0); check("rst_busy", int'(hilo0), 0); tick();
    // Back-to-back ALU: addu $3 then readers at ages 1,2,3,4
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0); tick();
    drive(0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0); check("alu_ex", int'(fwd_rs0), 1); tick();
    drive(0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0); check("alu_mem", int'(fwd_rs0), 2); tick();
    drive(0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0); check("alu_wb", int'(fwd_rs0), 3); tick();
    drive(0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0); check("alu_rf", int'(fwd_rs0), 0); tick();
    // Load-use
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0); tick();
    drive(0, 1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0); check("lu_stall", int'(stall0), 1); tick();
    drive(0, 1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    check("lu_fwd", int'(fwd_rt0), 2); check("lu_issue", int'(issue0), 1); tick();
    // $0 never tracked; youngest wins
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 1, 0, 0, 1, 7, 0, 0, 0); check("zero_reg", int'(fwd_rs0), 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0); tick();
    drive(0, 1, 0, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    check("youngest", int'(fwd_rs0), 1); check("rs_eq_rt", int'(fwd_rt0), 1); tick();
    // Branch on an EX producer
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0); tick();
    drive(0, 1, 0, 4, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    check("br_stall0", int'(stall0), 1); check("br_fwd1", int'(fwd_rs1), 1); tick();
    drive(0, 1, 0, 4, 0, 1, 0, 1, 0, 0, 0, 0, 0); check("br_fwd0", int'(fwd_rs0), 2); tick();
    // Divider window then mflo
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    repeat (4) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 1); check("div_stall", int'(stall0), 1); tick();
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 1);
    check("div_issue", int'(issue0), 1); check("div_idle", int'(hilo0), 0); tick();
    // Reset mid-divide
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_div_busy", int'(hilo0), 0); check("rst_div_stall", int'(stall0), 0); tick();
    // Flush overrides a pending load-use
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 6, 1, 0, 0); tick();
    drive(0, 1, 1, 0, 6, 0, 1, 0, 1, 8, 0, 0, 0);
    check("fl_stall", int'(stall0), 0); check("fl_issue", int'(issue0), 0); tick();
    drive(0, 1, 0, 0, 8, 0, 1, 0, 0, 0, 0, 0, 0); check("fl_bubble", int'(fwd_rt0), 0); tick();
    // Randomised traffic over a small register set to provoke hazards
    for (int i = 0; i < 1800; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 9),
            ($urandom_range(0, 9) == 0), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom),
            $urandom_range(0, 7), ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 5) == 0));
      tick();
    end
    check("perf_sat", int'(perf0), pcnt[0]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
